// File: rtl/thermal_mode_ctrl.sv
// Post-startup thermal scheduler: periodic ADC requests, 4-sample averaging,
// and NORMAL/HOT mode selection with threshold hysteresis and a dwell count.
module thermal_mode_ctrl #(
    parameter int SAMPLE_PERIOD = 64,
    parameter int TIMEOUT       = 16,
    parameter int HOT_TH        = 13,
    parameter int COOL_TH       = 7,
    parameter int DWELL         = 4
) (
    input  logic       i_clk,
    input  logic       i_resetbAll,
    input  logic       i_enable,
    input  logic       i_adc_valid,
    input  logic [3:0] i_adc_data,
    output logic       o_adc_start,
    output logic       o_Ibias_2x,
    output logic       o_clk_div_sel,
    output logic [3:0] o_avg,
    output logic       o_avg_valid,
    output logic       o_timeout_err
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ADC,
        S_WAIT_PERIOD,
        S_EVAL
    } state_t;

    state_t        state;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] to_cnt;
    logic [5:0]    sum;
    logic [2:0]    cnt;
    logic [3:0]    hot_cnt;
    logic [3:0]    cool_cnt;
    logic          hot_mode;
    logic [3:0]    avg;

    // Sum of four 4-bit codes fits in 6 bits; dividing by 4 simply drops the two LSBs.
    function automatic logic [3:0] trunc_avg(input logic [5:0] s);
        return s[5:2];
    endfunction

    assign avg           = trunc_avg(sum);
    assign o_Ibias_2x    = hot_mode;
    assign o_clk_div_sel = hot_mode;

    always_ff @(posedge i_clk) begin
        if (!i_resetbAll) begin
            state         <= S_IDLE;
            period_cnt    <= '0;
            to_cnt        <= '0;
            sum           <= '0;
            cnt           <= '0;
            hot_cnt       <= '0;
            cool_cnt      <= '0;
            hot_mode      <= 1'b0;
            o_adc_start   <= 1'b0;
            o_avg         <= '0;
            o_avg_valid   <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_adc_start <= 1'b0;
            o_avg_valid <= 1'b0;
            if (!i_enable) begin
                state    <= S_IDLE;
                sum      <= '0;
                cnt      <= '0;
                hot_cnt  <= '0;
                cool_cnt <= '0;
            end else begin
                // Both counters read 0 during the START cycle and count every cycle after it.
                period_cnt <= period_cnt + 1'b1;
                case (state)
                    S_IDLE: begin
                        state       <= S_START;
                        period_cnt  <= '0;
                        to_cnt      <= '0;
                        o_adc_start <= 1'b1;
                    end
                    S_START: begin
                        state  <= S_WAIT_ADC;
                        to_cnt <= to_cnt + 1'b1;
                    end
                    S_WAIT_ADC: begin
                        if (i_adc_valid) begin
                            sum   <= sum + {2'b00, i_adc_data};
                            cnt   <= cnt + 1'b1;
                            state <= (cnt == 3'd3) ? S_EVAL : S_WAIT_PERIOD;
                        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                            o_timeout_err <= 1'b1;
                            state         <= S_WAIT_PERIOD;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    S_WAIT_PERIOD: begin
                        if (period_cnt == PW'(SAMPLE_PERIOD - 1)) begin
                            state       <= S_START;
                            period_cnt  <= '0;
                            to_cnt      <= '0;
                            o_adc_start <= 1'b1;
                        end
                    end
                    S_EVAL: begin
                        o_avg       <= avg;
                        o_avg_valid <= 1'b1;
                        sum         <= '0;
                        cnt         <= '0;
                        state       <= S_WAIT_PERIOD;
                        if (!hot_mode) begin
                            if (avg >= 4'(HOT_TH)) begin
                                if (hot_cnt + 1'b1 == 4'(DWELL)) begin
                                    hot_mode <= 1'b1;
                                    hot_cnt  <= '0;
                                end else begin
                                    hot_cnt <= hot_cnt + 1'b1;
                                end
                            end else begin
                                hot_cnt <= '0;
                            end
                        end else begin
                            if (avg <= 4'(COOL_TH)) begin
                                if (cool_cnt + 1'b1 == 4'(DWELL)) begin
                                    hot_mode <= 1'b0;
                                    cool_cnt <= '0;
                                end else begin
                                    cool_cnt <= cool_cnt + 1'b1;
                                end
                            end else begin
                                cool_cnt <= '0;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_thermal_mode_ctrl.sv
// Directed bench for thermal_mode_ctrl: hand-computed averages, modes, timing and errors.
module tb_thermal_mode_ctrl;

    logic       i_clk = 1'b0;
    logic       i_resetbAll;
    logic       i_enable;
    logic       i_adc_valid;
    logic [3:0] i_adc_data;
    logic       o_adc_start;
    logic       o_Ibias_2x;
    logic       o_clk_div_sel;
    logic [3:0] o_avg;
    logic       o_avg_valid;
    logic       o_timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;
    bit chk_period = 1'b0;

    thermal_mode_ctrl dut (
        .i_clk        (i_clk),
        .i_resetbAll  (i_resetbAll),
        .i_enable     (i_enable),
        .i_adc_valid  (i_adc_valid),
        .i_adc_data   (i_adc_data),
        .o_adc_start  (o_adc_start),
        .o_Ibias_2x   (o_Ibias_2x),
        .o_clk_div_sel(o_clk_div_sel),
        .o_avg        (o_avg),
        .o_avg_valid  (o_avg_valid),
        .o_timeout_err(o_timeout_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output int c);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (o_adc_start === 1'b1) found = 1'b1;
        end
        chk("start_seen", 32'(found), 32'd1);
        c = cyc;
        if (chk_period) chk("start_period", 32'(c - last_start), 32'd64);
        last_start = c;
    endtask

    // Called in the start cycle; answers dly cycles later with a one-cycle valid.
    task automatic sample_at(input logic [3:0] code, input int dly);
        repeat (dly) tick();
        i_adc_valid = 1'b1;
        i_adc_data  = code;
        tick();
        i_adc_valid = 1'b0;
        i_adc_data  = 4'd0;
    endtask

    task automatic sample(input logic [3:0] code, input int dly);
        int c;
        wait_start(c);
        sample_at(code, dly);
    endtask

    // Called in the cycle after the 4th valid (the EVAL cycle).
    task automatic check_avg(input logic [3:0] exp_avg, input logic exp_mode);
        tick();
        chk("avg_valid", 32'(o_avg_valid), 32'd1);
        chk("avg", 32'(o_avg), 32'(exp_avg));
        chk("ibias", 32'(o_Ibias_2x), 32'(exp_mode));
        chk("clkdiv", 32'(o_clk_div_sel), 32'(exp_mode));
        tick();
        chk("avg_valid_pulse", 32'(o_avg_valid), 32'd0);
    endtask

    task automatic run_avg(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [3:0] exp_avg, input logic exp_mode);
        sample(a, 2);
        sample(b, 2);
        sample(c, 2);
        sample(d, 2);
        check_avg(exp_avg, exp_mode);
    endtask

    initial begin
        int c;
        int en_cyc;
        i_resetbAll = 1'b0;
        i_enable    = 1'b0;
        i_adc_valid = 1'b0;
        i_adc_data  = 4'd0;
        repeat (3) tick();
        chk("rst_start", 32'(o_adc_start), 32'd0);
        chk("rst_ibias", 32'(o_Ibias_2x), 32'd0);
        chk("rst_clkdiv", 32'(o_clk_div_sel), 32'd0);
        chk("rst_avg", 32'(o_avg), 32'd0);
        chk("rst_avg_valid", 32'(o_avg_valid), 32'd0);
        chk("rst_err", 32'(o_timeout_err), 32'd0);

        // Steady NORMAL operation with code 5, start spacing checked on the second average
        i_resetbAll = 1'b1;
        i_enable    = 1'b1;
        run_avg(5, 5, 5, 5, 5, 1'b0);
        chk_period = 1'b1;
        run_avg(5, 5, 5, 5, 5, 1'b0);
        chk_period = 1'b0;
        chk("err_normal", 32'(o_timeout_err), 32'd0);

        // Dwell broken by an average of 10, then four hot averages enter HOT
        run_avg(14, 14, 14, 14, 14, 1'b0);
        run_avg(14, 14, 14, 14, 14, 1'b0);
        run_avg(14, 14, 14, 14, 14, 1'b0);
        run_avg(10, 10, 10, 10, 10, 1'b0);
        run_avg(14, 14, 14, 14, 14, 1'b0);
        run_avg(14, 14, 14, 14, 14, 1'b0);
        run_avg(14, 14, 14, 14, 14, 1'b0);
        run_avg(14, 14, 14, 14, 14, 1'b1);

        // Enable drop after two samples: partial sum discarded, mode kept, immediate restart
        sample(15, 2);
        sample(15, 2);
        i_enable = 1'b0;
        repeat (4) tick();
        chk("dis_start", 32'(o_adc_start), 32'd0);
        chk("dis_mode", 32'(o_Ibias_2x), 32'd1);
        chk("dis_avg", 32'(o_avg), 32'd14);
        i_enable = 1'b1;
        en_cyc = cyc;
        wait_start(c);
        chk("restart_latency", 32'(c - en_cyc), 32'd1);
        sample_at(10, 2);
        sample(10, 2);
        sample(10, 2);
        sample(10, 2);
        check_avg(10, 1'b1);

        // HOT: 10 holds, NORMAL only on the fourth average of 6
        run_avg(10, 10, 10, 10, 10, 1'b1);
        run_avg(6, 6, 6, 6, 6, 1'b1);
        run_avg(6, 6, 6, 6, 6, 1'b1);
        run_avg(6, 6, 6, 6, 6, 1'b1);
        run_avg(6, 6, 6, 6, 6, 1'b0);

        // Valid arriving on the last allowed cycle is accepted without error
        sample(4, 15);
        chk("late_valid_err", 32'(o_timeout_err), 32'd0);
        sample(4, 2);
        sample(4, 2);
        sample(4, 2);
        check_avg(4, 1'b0);

        // Missing valid: error at 16th cycle after start, sample skipped
        wait_start(c);
        repeat (15) tick();
        chk("timeout_early", 32'(o_timeout_err), 32'd0);
        tick();
        chk("timeout_set", 32'(o_timeout_err), 32'd1);
        run_avg(3, 3, 3, 3, 3, 1'b0);
        chk("timeout_sticky", 32'(o_timeout_err), 32'd1);

        // Full-scale sum and truncating divide
        run_avg(15, 15, 15, 15, 15, 1'b0);
        run_avg(1, 2, 2, 2, 1, 1'b0);

        // Back to HOT, then reset mid-conversion
        run_avg(14, 14, 14, 14, 14, 1'b0);
        run_avg(14, 14, 14, 14, 14, 1'b0);
        run_avg(14, 14, 14, 14, 14, 1'b0);
        run_avg(14, 14, 14, 14, 14, 1'b1);
        wait_start(c);
        tick();
        i_resetbAll = 1'b0;
        tick();
        chk("mid_rst_start", 32'(o_adc_start), 32'd0);
        chk("mid_rst_ibias", 32'(o_Ibias_2x), 32'd0);
        chk("mid_rst_clkdiv", 32'(o_clk_div_sel), 32'd0);
        chk("mid_rst_avg", 32'(o_avg), 32'd0);
        chk("mid_rst_avg_valid", 32'(o_avg_valid), 32'd0);
        chk("mid_rst_err", 32'(o_timeout_err), 32'd0);
        i_resetbAll = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
